// File: rtl/julia_pixel_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : julia_pixel_scheduler_if
//  Purpose  : Frame request, Julia constant and pixel-job stream bundle.
//  Revision : 1.0
// ============================================================================
interface julia_pixel_scheduler_if #(
    parameter int WIDTH = 20
);
    logic                    start;
    logic signed [WIDTH-1:0] x_min;
    logic signed [WIDTH-1:0] y_max;
    logic signed [WIDTH-1:0] step;
    logic signed [WIDTH-1:0] c_real_in;
    logic signed [WIDTH-1:0] c_imag_in;
    logic signed [WIDTH-1:0] z_real_out;
    logic signed [WIDTH-1:0] z_imag_out;
    logic signed [WIDTH-1:0] c_real_out;
    logic signed [WIDTH-1:0] c_imag_out;
    logic [15:0]             pix_x;
    logic [15:0]             pix_y;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;
    logic                    done;

    // Scheduler side: produces pixel jobs
    modport master (
        input  start, x_min, y_max, step, c_real_in, c_imag_in, out_ready,
        output z_real_out, z_imag_out, c_real_out, c_imag_out,
               pix_x, pix_y, out_valid, busy, done
    );

    // Requester / iteration-engine side
    modport slave (
        output start, x_min, y_max, step, c_real_in, c_imag_in, out_ready,
        input  z_real_out, z_imag_out, c_real_out, c_imag_out,
               pix_x, pix_y, out_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/julia_pixel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : julia_pixel_scheduler
//  Purpose  : Walks a frame in raster order, emitting one initial-z job per pixel.
//  Revision : 1.0
// ============================================================================
module julia_pixel_scheduler #(
    parameter int WIDTH      = 20,
    parameter int FRACTIONAL = 10,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480
) (
    input  logic                    clk,
    input  logic                    rst,
    julia_pixel_scheduler_if.master bus
);

    if (FRACTIONAL >= WIDTH) begin : g_bad_fractional
        $error("FRACTIONAL must be smaller than WIDTH");
    end

    localparam logic [15:0] C_LAST_COL = 16'(H_RES - 1);
    localparam logic [15:0] C_LAST_ROW = 16'(V_RES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic signed [WIDTH-1:0] r_x_min;
    logic signed [WIDTH-1:0] r_step;
    logic signed [WIDTH-1:0] r_c_real;
    logic signed [WIDTH-1:0] r_c_imag;
    logic signed [WIDTH-1:0] r_z_real;
    logic signed [WIDTH-1:0] r_z_imag;
    logic [15:0]             r_pix_x;
    logic [15:0]             r_pix_y;

    logic w_launch;
    logic w_transfer;
    logic w_last_col;
    logic w_last_row;

    assign w_launch   = (r_state == ST_IDLE) && bus.start;
    assign w_transfer = (r_state == ST_EMIT) && bus.out_ready;
    assign w_last_col = (r_pix_x == C_LAST_COL);
    assign w_last_row = (r_pix_y == C_LAST_ROW);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_next = ST_EMIT;
            ST_EMIT: if (w_transfer && w_last_col && w_last_row) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Incremental stepping only: column adds step, row reloads x_min and subtracts step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_min  <= '0;
            r_step   <= '0;
            r_c_real <= '0;
            r_c_imag <= '0;
            r_z_real <= '0;
            r_z_imag <= '0;
            r_pix_x  <= '0;
            r_pix_y  <= '0;
        end else if (w_launch) begin
            r_x_min  <= bus.x_min;
            r_step   <= bus.step;
            r_c_real <= bus.c_real_in;
            r_c_imag <= bus.c_imag_in;
            r_z_real <= bus.x_min;
            r_z_imag <= bus.y_max;
            r_pix_x  <= '0;
            r_pix_y  <= '0;
        end else if (w_transfer) begin
            if (!w_last_col) begin
                r_pix_x  <= r_pix_x + 16'd1;
                r_z_real <= r_z_real + r_step;
            end else if (!w_last_row) begin
                r_pix_x  <= '0;
                r_pix_y  <= r_pix_y + 16'd1;
                r_z_real <= r_x_min;
                r_z_imag <= r_z_imag - r_step;
            end
        end
    end

    assign bus.z_real_out = r_z_real;
    assign bus.z_imag_out = r_z_imag;
    assign bus.c_real_out = r_c_real;
    assign bus.c_imag_out = r_c_imag;
    assign bus.pix_x      = r_pix_x;
    assign bus.pix_y      = r_pix_y;
    assign bus.out_valid  = (r_state == ST_EMIT);
    assign bus.busy       = (r_state == ST_EMIT);
    assign bus.done       = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_julia_pixel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_julia_pixel_scheduler
//  Purpose  : Directed self-checking bench for a 4x3 Q10 frame.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_julia_pixel_scheduler;

    localparam int C_WIDTH = 20;
    localparam int C_H     = 4;
    localparam int C_V     = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    always #5 clk = ~clk;

    julia_pixel_scheduler_if #(.WIDTH(C_WIDTH)) bus ();

    julia_pixel_scheduler #(
        .WIDTH      (C_WIDTH),
        .FRACTIONAL (10),
        .H_RES      (C_H),
        .V_RES      (C_V)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_value(input string tag, input int observed, input int expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_job(input int x, input int y, input int zr, input int zi);
        check_value("out_valid", int'(bus.out_valid), 1);
        check_value("pix_x", int'(bus.pix_x), x);
        check_value("pix_y", int'(bus.pix_y), y);
        check_value("z_real", int'(bus.z_real_out), zr);
        check_value("z_imag", int'(bus.z_imag_out), zi);
    endtask

    task automatic start_frame(input int xmin, input int ymax, input int stp);
        bus.x_min = C_WIDTH'(xmin);
        bus.y_max = C_WIDTH'(ymax);
        bus.step  = C_WIDTH'(stp);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Advances with out_ready=1 until pixel (x,y) is on offer; bounded.
    task automatic run_until(input int x, input int y);
        for (int i = 0; i < 64; i++) begin
            if (bus.out_valid === 1'b1 && int'(bus.pix_x) == x && int'(bus.pix_y) == y) return;
            tick();
        end
        check_value("reach_pixel", int'(bus.pix_x) + 16 * int'(bus.pix_y), x + 16 * y);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_min     = '0;
        bus.y_max     = '0;
        bus.step      = '0;
        bus.c_real_in = C_WIDTH'(-800);
        bus.c_imag_in = C_WIDTH'(160);
        tick();
        tick();
        check_value("rst_out_valid", int'(bus.out_valid), 0);
        check_value("rst_busy", int'(bus.busy), 0);
        check_value("rst_done", int'(bus.done), 0);
        check_value("rst_pix_x", int'(bus.pix_x), 0);
        check_value("rst_z_real", int'(bus.z_real_out), 0);
        check_value("rst_c_real", int'(bus.c_real_out), 0);
        rst = 1'b0;
        tick();

        // Full frame, ready always high
        bus.out_ready = 1'b1;
        start_frame(-2048, 1024, 512);
        check_value("c_real_latched", int'(bus.c_real_out), -800);
        check_value("c_imag_latched", int'(bus.c_imag_out), 160);
        check_value("busy_emit", int'(bus.busy), 1);
        for (int n = 0; n < C_H * C_V; n++) begin
            check_job(n % C_H, n / C_H, -2048 + 512 * (n % C_H), 1024 - 512 * (n / C_H));
            check_value("done_mid_frame", int'(bus.done), 0);
            tick();
        end
        check_value("done_pulse", int'(bus.done), 1);
        check_value("valid_in_done", int'(bus.out_valid), 0);
        tick();
        check_value("done_one_cycle", int'(bus.done), 0);
        check_value("valid_idle", int'(bus.out_valid), 0);

        // Stall at (2,1), then mid-frame start / x_min change
        start_frame(-2048, 1024, 512);
        run_until(2, 1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_job(2, 1, -1024, 512);
            tick();
        end
        check_job(2, 1, -1024, 512);
        bus.out_ready = 1'b1;
        tick();
        check_job(3, 1, -512, 512);
        bus.start     = 1'b1;
        bus.x_min     = '0;
        bus.c_real_in = C_WIDTH'(999);
        tick();
        bus.start = 1'b0;
        check_job(0, 2, -2048, 0);
        check_value("c_real_held", int'(bus.c_real_out), -800);
        bus.x_min     = C_WIDTH'(-2048);
        bus.c_real_in = C_WIDTH'(-800);
        run_until(3, 2);
        check_job(3, 2, -512, 0);
        tick();
        check_value("done_pulse_2", int'(bus.done), 1);

        // Back-to-back: start held through DONE into the following IDLE cycle
        bus.start = 1'b1;
        tick();
        check_value("b2b_idle_valid", int'(bus.out_valid), 0);
        check_value("b2b_idle_done", int'(bus.done), 0);
        tick();
        bus.start = 1'b0;
        check_job(0, 0, -2048, 1024);

        // Reset at (1,1) with start and a pending transfer in the same cycle
        run_until(1, 1);
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        check_value("mid_rst_valid", int'(bus.out_valid), 0);
        check_value("mid_rst_pix_x", int'(bus.pix_x), 0);
        check_value("mid_rst_pix_y", int'(bus.pix_y), 0);
        check_value("mid_rst_z_imag", int'(bus.z_imag_out), 0);
        check_value("mid_rst_c_imag", int'(bus.c_imag_out), 0);
        for (int i = 0; i < 3; i++) begin
            check_value("mid_rst_no_done", int'(bus.done), 0);
            check_value("mid_rst_idle", int'(bus.out_valid), 0);
            tick();
        end
        start_frame(-2048, 1024, 512);
        check_job(0, 0, -2048, 1024);
        run_until(3, 2);
        tick();
        check_value("done_after_restart", int'(bus.done), 1);
        tick();

        // Two's complement wrap: 0x7FC00 (+511.0) stepping by 1.0
        start_frame(32'h0007_FC00, 1024, 1024);
        check_job(0, 0, 523264, 1024);
        tick();
        check_job(1, 0, -524288, 1024);
        tick();
        check_job(2, 0, -523264, 1024);
        tick();
        check_job(3, 0, -522240, 1024);
        tick();
        check_job(0, 1, 523264, 0);
        run_until(3, 2);
        check_job(3, 2, -522240, -1024);
        tick();
        check_value("done_wrap", int'(bus.done), 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
